// File: rtl/seg_display_pkg.sv
// Shared constants and types for the seven-segment display scanner.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg_display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef enum logic {PH_BLANK, PH_DRIVE} phase_t;

endpackage

// File: rtl/seg_display_scanner_bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment decoder.
// Non-decimal nibbles (A-F) decode to an all-off pattern.
module bcd_to_seg7
  import seg_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd < 4'd10) seg = SEG_TABLE[bcd];
  end

endmodule

// File: rtl/seg_display_scanner.sv
// Four-digit multiplexed seven-segment scanner with double-buffered load.
// Optional per-digit blinking is compiled in with SEG_DISPLAY_SCANNER_BLINK_EN.
//
//   phase    | meaning
//   PH_BLANK | first BLANK_CYCLES of a slot, all anodes off (anti-ghosting)
//   PH_DRIVE | remainder of the slot, selected digit driven
module seg_display_scanner
  import seg_display_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
`ifdef SEG_DISPLAY_SCANNER_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           digits_in,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic                  load_valid,
  output logic                  load_ready,
`ifdef SEG_DISPLAY_SCANNER_BLINK_EN
  input  logic [NUM_DIGITS-1:0] blink_mask,
`endif
  output logic [1:0]            scan_sel,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  logic [15:0]           cnt;
  logic [15:0]           active_digits, pending_digits;
  logic [NUM_DIGITS-1:0] active_dp, pending_dp;
  logic                  pending_full;

  logic       slot_end, frame_end, hide, show;
  phase_t     phase;
  logic [3:0] cur_digit;
  logic [6:0] dec_seg;

  assign slot_end   = (cnt == 16'(REFRESH_DIV - 1));
  assign frame_end  = slot_end && (scan_sel == 2'd3);
  assign phase      = (cnt < 16'(BLANK_CYCLES)) ? PH_BLANK : PH_DRIVE;
  assign cur_digit  = active_digits[{scan_sel, 2'b00} +: 4];
  assign load_ready = ~pending_full;
  assign show       = (phase == PH_DRIVE) && !hide;

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

`ifdef SEG_DISPLAY_SCANNER_BLINK_EN
  localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FCW-1:0] frame_cnt;
  logic           blink_phase;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (frame_cnt == FCW'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign hide = blink_phase && blink_mask[scan_sel];
`else
  assign hide = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt            <= '0;
      scan_sel       <= '0;
      frame_done     <= 1'b0;
      active_digits  <= 16'hFFFF;
      pending_digits <= 16'hFFFF;
      active_dp      <= '0;
      pending_dp     <= '0;
      pending_full   <= 1'b0;
      anode          <= '1;
      seg            <= SEG_BLANK;
      dp             <= 1'b1;
    end else begin
      cnt        <= slot_end ? '0 : cnt + 16'd1;
      frame_done <= frame_end;
      if (slot_end) scan_sel <= scan_sel + 2'd1;

      // A load and a transfer are mutually exclusive: loads need pending empty.
      if (frame_end && pending_full) begin
        active_digits <= pending_digits;
        active_dp     <= pending_dp;
        pending_full  <= 1'b0;
      end else if (load_valid && load_ready) begin
        pending_digits <= digits_in;
        pending_dp     <= dp_in;
        pending_full   <= 1'b1;
      end

      if (show) begin
        anode <= ~(NUM_DIGITS'(1) << scan_sel);
        seg   <= dec_seg;
        dp    <= ~active_dp[scan_sel];
      end else begin
        anode <= '1;
        seg   <= SEG_BLANK;
        dp    <= 1'b1;
      end
    end
  end

endmodule

// File: doc/seg_display_scanner.md
Name: seg_display_scanner

Overview:
- Sink-side display driver for the alarm clock's four multiplexed seven-segment digits.
- Accepts four BCD digits plus decimal points through a valid/ready load handshake and double-buffers them.
- Runs its own digit-scan sequencer with a refresh prescaler and an anti-ghosting blank interval.
- Drives active-low anode and segment lines directly to the board.

Parameters:
- REFRESH_DIV, 50000: clk cycles per digit slot; legal range 2..65535.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off; must be less than REFRESH_DIV.
- BLINK_FRAMES, 64: frames per blink half-period; used only with BLINK_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- digits_in  in  16  four BCD nibbles; [3:0] is digit 0 (rightmost).
- dp_in  in  4  decimal point per digit; 1 = lit.
- load_valid  in  1  digits_in/dp_in are valid this cycle.
- load_ready  out  1  pending buffer is empty and can accept a load.
- blink_mask  in  4  per-digit blink enable; present only with BLINK_EN.
- scan_sel  out  2  index of the digit slot currently being scanned.
- anode  out  4  active-low digit enables.
- seg  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- dp  out  1  active-low decimal point.
- frame_done  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (asserted, async): anode=4'b1111, seg=7'h7F, dp=1, scan_sel=0, frame_done=0, load_ready=1. Prescaler=0; active and pending digits=4'hF each (blank); dp buffers=0; pending_full=0.
- Prescaler: cnt runs 0..REFRESH_DIV-1, then wraps to 0.
- Slot advance: on the cycle where cnt==REFRESH_DIV-1, scan_sel increments modulo 4 (3 wraps to 0).
- Slot phases: BLANK while cnt<BLANK_CYCLES; DRIVE otherwise.
- Output registration: anode/seg/dp are registered from the current cnt/scan_sel/active buffer, so they lag phase changes by exactly 1 cycle.
- BLANK output: anode=1111, seg=7F, dp=1.
- DRIVE output: anode has only bit scan_sel low. seg = decode(active digit[scan_sel]). dp = ~active_dp[scan_sel].
- Decode: BCD 0-9 use standard patterns (0 -> 7'h40, 1 -> 7'h79, 8 -> 7'h00). Nibbles A-F give blank (7'h7F) but the anode is still driven.
- Handshake:
  - load_ready = ~pending_full.
  - load_valid&&load_ready captures into the pending buffer and sets pending_full.
  - load_valid while not ready is ignored; there is no queuing.
- Frame boundary (cnt==REFRESH_DIV-1 && scan_sel==3):
  - frame_done is registered high for the next cycle.
  - If pending_full, pending copies to active and pending_full clears.
- Simultaneous load and boundary with pending empty: the load captures into pending but is not bypassed to active; it is applied at the following boundary.
- Boundary with pending full: transfer happens and load_ready rises the next cycle.
- Reset mid-frame or mid-load: everything returns to reset values immediately; a load in flight is lost.
- Active digits change only at frame boundaries, so no tearing within a frame.

Optional Feature:
- Macro: SEG_DISPLAY_SCANNER_BLINK_EN.
- Enabled:
  - blink_mask port exists.
  - A frame counter 0..BLINK_FRAMES-1 toggles blink_phase at wrap; blink_phase resets to 0 (visible).
  - While blink_phase=1, a digit whose mask bit is set stays in the BLANK output pattern during its DRIVE phase.
  - blink_mask is sampled every cycle.
- Disabled: the blink_mask port, counter and phase logic are absent; all digits are always driven.

Decomposition:
- Package seg_display_pkg:
  - NUM_DIGITS=4.
  - SEG_BLANK=7'h7F.
  - The 10-entry segment constant table.
  - Phase encoding typedef {PH_BLANK, PH_DRIVE}.
- Sub-module bcd_to_seg7: purely combinational nibble-to-segment decoder, instantiated once on the muxed digit.

Test Plan:
Use REFRESH_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2.
- Reset release, no load -> anode toggles 1111 (2 cycles) / 1110 (6 cycles) for slot 0, then 1101, 1011, 0111; seg stays 7F throughout; frame_done pulses every 32 cycles.
- Load digits_in=16'h1234, dp_in=4'b0001 -> load_ready drops next cycle. After the next frame_done: slot 0 seg=decode(4) with dp=0, slot 3 seg=7'h79; load_ready returns to 1.
- Second load while pending full -> load_ready=0, so the second load is ignored. Only the first value appears; after the boundary a retried load is accepted.
- load_valid on the exact boundary cycle with pending empty -> active unchanged for that frame; the new value is shown from the subsequent frame.
- reset asserted mid-DRIVE of slot 2 -> anode=1111, seg=7F and scan_sel=0 immediately (async), and the active buffer is blank.
- BLINK_EN defined, blink_mask=4'b1000, digits 16'h1234 -> digit 3 is lit for 2 frames and blank for 2 frames; digits 0-2 stay lit continuously.
